csr_timer_bank: RTL and testbench
=================================

// Module: csr_timer_bank
// PURPOSE
//   Parametrised bank of NUM_TIMERS independent countdown timers with CSR-mapped
//   TCFG/TVAL/TICLR per channel, optional shared prescaler, and a free-running
//   stable counter. Sits beside the CSR file in the WB stage.
//   Per-channel pending bits feed ESTAT.IS via timer_irq; CSR reads are muxed in
//   by the CSR file. Channel 0 defaults keep the single-timer address map
//   (TCFG 0x41, TVAL 0x42, TICLR 0x44).
// PARAMETERS
//   NUM_TIMERS  2      number of timer channels (1..8)
//   CNT_WIDTH   32     counter width in bits (8..32); INITVAL is CNT_WIDTH-2 bits
//   PRESCALE    1      timers decrement once per PRESCALE clocks (1..256)
//   TIMER_BASE  14'h41 CSR number of channel 0 TCFG; channel i at TIMER_BASE+4*i
//   STABLE_W    64     stable counter width
// PORTS
//   clk                   in   1           clock
//   reset                 in   1           synchronous, active-high reset
//   csr_re                in   1           CSR read enable
//   csr_num               in   14          CSR number
//   csr_we                in   1           CSR write enable
//   csr_wmask             in   32          per-bit write mask
//   csr_wvalue            in   32          write data
//   csr_rvalue            out  32          read data; 0 if !csr_re or no address hit
//   csr_hit               out  1           csr_num decodes to a TCFG/TVAL/TICLR here
//   timer_irq             out  NUM_TIMERS  per-channel pending interrupt
//   stable_counter_value  out  STABLE_W    free-running cycle count
// BEHAVIOUR
// - Map per channel i (A = TIMER_BASE+4*i):
//     A+0 TCFG  {INITVAL, PERIODIC, EN}, zero-extended to 32 bits.
//     A+1 TVAL  (read-only).
//     A+3 TICLR (write-only; reads 0).
//     A+2 is unmapped: reads 0, csr_hit=0.
// - Reads are combinational, same-cycle. TVAL returns the live counter, zero-extended.
//   Writes to TVAL are ignored.
// - TCFG write: new = wmask&wvalue | ~wmask&old, taking the low CNT_WIDTH bits.
//   If new.EN=1, cnt <= {new.INITVAL,2'b00} on the same edge.
//   If new.EN=0, cnt holds its value.
// - Prescaler: a shared counter runs 0..PRESCALE-1 and produces tick when it is at
//   PRESCALE-1. It runs continuously from reset. With PRESCALE=1, tick=1 every cycle.
// - Each channel, on a cycle with EN && tick && cnt != all-ones:
//     cnt==0 && PERIODIC  -> cnt <= {INITVAL,2'b00}
//     otherwise           -> cnt <= cnt-1. One-shot goes 0 -> all-ones and then holds.
// - Pending set: EN && tick && cnt==0. Once per expiry, since cnt leaves 0 on that tick.
// - Pending clear: TICLR write with wmask[0]&wvalue[0]. Set wins over clear in the
//   same cycle. Writing 0 has no effect.
// - Priority on cnt: reset > TCFG write (EN=1) > tick decrement/reload.
//   If a TCFG write and an expiry fall in the same cycle, the write loads cnt AND
//   pending still sets.
// - Channels are fully independent. A write to channel i never alters channel j.
// - stable_counter_value increments every cycle and wraps modulo 2^STABLE_W.
// - Reset values:
//     EN=0, PERIODIC=0, INITVAL=0, cnt=all-ones, pending=0;
//     prescaler=0, stable counter=0.
//   csr_rvalue follows the reset state (TCFG reads 0, TVAL reads all-ones).
// - Reset mid-count aborts all timers and drops timer_irq on the next edge.
// - No multicycle paths. All state updates on posedge clk.
// TESTING
// 1. PRESCALE=1, write TCFG0 0x15 (init=5, one-shot, EN) ->
//    - next cycle TVAL=0x14, then one decrement per cycle;
//    - timer_irq[0] rises the cycle after TVAL==0;
//    - TVAL then holds 0xFFFFFFFF.
// 2. Write TCFG0 0x17 (periodic) ->
//    - TVAL cycles 0x14..0, reloading 0x14;
//    - pending sets each 21 cycles;
//    - TICLR0 write 0x1 clears it; a clear coinciding with expiry leaves it set.
// 3. PRESCALE=4, TCFG1 (csr 0x45) = 0x9 (init=2, one-shot, EN) ->
//    - TVAL1 steps 8,7,...,0 with 4 cycles per step;
//    - timer_irq[1] only, channel 0 untouched.
// 4. Masked writes:
//    - TCFG0 wmask=0x1 with wvalue=0xFFFFFFFF loads the existing INITVAL<<2;
//    - a TVAL write leaves TVAL unchanged;
//    - a read of 0x43 or with csr_re=0 returns 0.
// 5. Assert reset mid-count in periodic mode ->
//    - next cycle TVAL=0xFFFFFFFF, TCFG=0, timer_irq=0, stable counter=0;
//    - the counter never moves until re-enabled.

Source files
------------

// File: rtl/csr_timer_bank.sv
// Bank of independent countdown timers behind CSR-mapped TCFG/TVAL/TICLR registers,
// with a shared prescaler and a free-running stable counter.
module csr_timer_bank #(
    parameter int          NUM_TIMERS = 2,
    parameter int          CNT_WIDTH  = 32,
    parameter int          PRESCALE   = 1,
    parameter logic [13:0] TIMER_BASE = 14'h41,
    parameter int          STABLE_W   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csr_re,
    input  logic [13:0]           csr_num,
    input  logic                  csr_we,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wvalue,
    output logic [31:0]           csr_rvalue,
    output logic                  csr_hit,
    output logic [NUM_TIMERS-1:0] timer_irq,
    output logic [STABLE_W-1:0]   stable_counter_value
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]         pre_cnt;
    logic                  tick;
    logic [STABLE_W-1:0]   stable_cnt;

    logic [NUM_TIMERS-1:0] hit_cfg;
    logic [NUM_TIMERS-1:0] hit_val;
    logic [NUM_TIMERS-1:0] hit_clr;
    logic [31:0]           rd_ch [NUM_TIMERS];

    // With PRESCALE=1 the counter is pinned at 0, so tick is constantly high.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + STABLE_W'(1);
        end
    end

    assign stable_counter_value = stable_cnt;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        localparam logic [13:0] ADDR = 14'(TIMER_BASE + 14'(4 * i));

        logic [CNT_WIDTH-1:0] tcfg_q;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic                 pend_q;
        logic [CNT_WIDTH-1:0] cfg_new;
        logic                 cfg_we;
        logic                 clr;
        logic                 en;
        logic                 periodic;
        logic [CNT_WIDTH-3:0] initval;
        logic                 expire;

        assign hit_cfg[i] = (csr_num == ADDR);
        assign hit_val[i] = (csr_num == ADDR + 14'd1);
        assign hit_clr[i] = (csr_num == ADDR + 14'd3);

        assign cfg_new  = (csr_wmask[CNT_WIDTH-1:0] & csr_wvalue[CNT_WIDTH-1:0])
                        | (~csr_wmask[CNT_WIDTH-1:0] & tcfg_q);
        assign cfg_we   = csr_we & hit_cfg[i];
        assign clr      = csr_we & hit_clr[i] & csr_wmask[0] & csr_wvalue[0];
        assign en       = tcfg_q[0];
        assign periodic = tcfg_q[1];
        assign initval  = tcfg_q[CNT_WIDTH-1:2];
        assign expire   = en & tick & (cnt_q == '0);

        // A disabling TCFG write freezes cnt on that edge instead of letting it tick.
        always_ff @(posedge clk) begin
            if (reset) begin
                tcfg_q <= '0;
                cnt_q  <= '1;
                pend_q <= 1'b0;
            end else begin
                if (cfg_we) begin
                    tcfg_q <= cfg_new;
                end
                if (cfg_we) begin
                    if (cfg_new[0]) begin
                        cnt_q <= {cfg_new[CNT_WIDTH-1:2], 2'b00};
                    end
                end else if (en && tick && (cnt_q != '1)) begin
                    if ((cnt_q == '0) && periodic) begin
                        cnt_q <= {initval, 2'b00};
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                if (expire) begin
                    pend_q <= 1'b1;
                end else if (clr) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign timer_irq[i] = pend_q;
        assign rd_ch[i]     = hit_cfg[i] ? 32'(tcfg_q) :
                              hit_val[i] ? 32'(cnt_q)  : 32'h0;
    end

    assign csr_hit = |(hit_cfg | hit_val | hit_clr);

    always_comb begin
        csr_rvalue = '0;
        if (csr_re) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                csr_rvalue = csr_rvalue | rd_ch[i];
            end
        end
    end

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: one instance at PRESCALE=1, one at PRESCALE=4,
// sharing the CSR bus; expected values are hand-computed per step.
module tb_csr_timer_bank;

    logic        clk;
    logic        reset;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;

    logic [31:0] rv1, rv4;
    logic        hit1, hit4;
    logic [1:0]  irq1, irq4;
    logic [63:0] st1, st4;

    int checks   = 0;
    int failures = 0;

    csr_timer_bank #(.NUM_TIMERS(2), .CNT_WIDTH(32), .PRESCALE(1),
                     .TIMER_BASE(14'h41), .STABLE_W(64)) dut1 (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_rvalue(rv1), .csr_hit(hit1), .timer_irq(irq1),
        .stable_counter_value(st1)
    );

    csr_timer_bank #(.NUM_TIMERS(2), .CNT_WIDTH(32), .PRESCALE(4),
                     .TIMER_BASE(14'h41), .STABLE_W(64)) dut4 (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_rvalue(rv4), .csr_hit(hit4), .timer_irq(irq4),
        .stable_counter_value(st4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_we     = 1'b1;
        csr_num    = num;
        csr_wmask  = mask;
        csr_wvalue = val;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [13:0] num);
        csr_re  = 1'b1;
        csr_num = num;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        csr_re     = 1'b0;
        csr_num    = '0;
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
        step(2);

        // reset state
        rd(14'h41); chk("rst_tcfg0", rv1, 32'h0);
        rd(14'h42); chk("rst_tval0", rv1, 32'hFFFF_FFFF);
        rd(14'h46); chk("rst_tval1", rv1, 32'hFFFF_FFFF);
        chk("rst_irq", irq1, 2'b00);
        chk("rst_stable", st1, 64'd0);
        reset = 1'b0;

        // one-shot, init=5
        wr(14'h41, 32'hFFFF_FFFF, 32'h15);
        rd(14'h42); chk("os_load", rv1, 32'h14);
        chk("os_hit", hit1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            rd(14'h42); chk("os_dec", rv1, 32'h14 - 32'(k));
        end
        chk("os_irq_before", irq1, 2'b00);
        step(1);
        rd(14'h42); chk("os_wrap", rv1, 32'hFFFF_FFFF);
        chk("os_irq_set", irq1, 2'b01);
        step(5);
        rd(14'h42); chk("os_hold", rv1, 32'hFFFF_FFFF);

        // TICLR with data 0 does nothing; data 1 clears
        wr(14'h44, 32'h1, 32'h0);
        chk("clr_zero", irq1, 2'b01);
        wr(14'h44, 32'h1, 32'h1);
        chk("clr_one", irq1, 2'b00);

        // periodic, init=5
        wr(14'h41, 32'hFFFF_FFFF, 32'h17);
        rd(14'h42); chk("per_load", rv1, 32'h14);
        step(20);
        rd(14'h42); chk("per_zero", rv1, 32'h0);
        chk("per_irq_before", irq1, 2'b00);
        step(1);
        rd(14'h42); chk("per_reload", rv1, 32'h14);
        chk("per_irq_set", irq1, 2'b01);
        wr(14'h44, 32'h1, 32'h1);
        chk("per_clr", irq1, 2'b00);
        rd(14'h42); chk("per_after_clr", rv1, 32'h13);
        step(19);
        rd(14'h42); chk("per_zero2", rv1, 32'h0);
        wr(14'h44, 32'h1, 32'h1);
        chk("per_set_wins", irq1, 2'b01);
        rd(14'h42); chk("per_reload2", rv1, 32'h14);

        // masked writes and decode
        wr(14'h41, 32'h1, 32'h0);
        rd(14'h41); chk("dis_tcfg", rv1, 32'h16);
        rd(14'h42); chk("dis_hold", rv1, 32'h14);
        wr(14'h41, 32'hFFFF_FFFF, 32'h1C);
        rd(14'h41); chk("newinit_tcfg", rv1, 32'h1C);
        step(3);
        rd(14'h42); chk("newinit_hold", rv1, 32'h14);
        wr(14'h41, 32'h1, 32'hFFFF_FFFF);
        rd(14'h41); chk("mask_tcfg", rv1, 32'h1D);
        rd(14'h42); chk("mask_load", rv1, 32'h1C);
        wr(14'h42, 32'hFFFF_FFFF, 32'h5);
        rd(14'h42); chk("tval_ro", rv1, 32'h1B);
        rd(14'h43); chk("unmapped_rd", rv1, 32'h0);
        chk("unmapped_hit", hit1, 1'b0);
        rd(14'h44); chk("ticlr_rd", rv1, 32'h0);
        chk("ticlr_hit", hit1, 1'b1);
        csr_re  = 1'b0;
        csr_num = 14'h41;
        #1;
        chk("no_re_rd", rv1, 32'h0);
        chk("no_re_hit", hit1, 1'b1);
        rd(14'h45); chk("ch1_tcfg_untouched", rv1, 32'h0);
        rd(14'h46); chk("ch1_tval_untouched", rv1, 32'hFFFF_FFFF);
        chk("ch1_irq_untouched", irq1[1], 1'b0);

        // PRESCALE=4, channel 1 one-shot init=2
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        wr(14'h45, 32'hFFFF_FFFF, 32'h9);
        rd(14'h46); chk("ps_load", rv4, 32'h8);
        step(2);
        rd(14'h46); chk("ps_hold", rv4, 32'h8);
        step(1);
        rd(14'h46); chk("ps_step1", rv4, 32'h7);
        for (int m = 2; m <= 8; m++) begin
            step(3);
            rd(14'h46); chk("ps_mid", rv4, 32'h8 - 32'(m - 1));
            step(1);
            rd(14'h46); chk("ps_step", rv4, 32'h8 - 32'(m));
        end
        chk("ps_irq_before", irq4, 2'b00);
        step(3);
        rd(14'h46); chk("ps_zero_hold", rv4, 32'h0);
        step(1);
        rd(14'h46); chk("ps_wrap", rv4, 32'hFFFF_FFFF);
        chk("ps_irq", irq4, 2'b10);
        rd(14'h42); chk("ps_ch0_tval", rv4, 32'hFFFF_FFFF);
        rd(14'h41); chk("ps_ch0_tcfg", rv4, 32'h0);

        // reset mid-count in periodic mode
        wr(14'h41, 32'hFFFF_FFFF, 32'h17);
        step(21);
        rd(14'h42); chk("mr_reload", rv1, 32'h14);
        chk("mr_irq", irq1[0], 1'b1);
        step(3);
        rd(14'h42); chk("mr_mid", rv1, 32'h11);
        reset = 1'b1;
        step(1);
        rd(14'h42); chk("mr_tval", rv1, 32'hFFFF_FFFF);
        rd(14'h41); chk("mr_tcfg", rv1, 32'h0);
        chk("mr_irq_drop", irq1, 2'b00);
        chk("mr_stable", st1, 64'd0);
        reset = 1'b0;
        step(5);
        rd(14'h42); chk("mr_idle", rv1, 32'hFFFF_FFFF);
        chk("mr_stable_run", st1, 64'd5);
        chk("mr_irq_idle", irq1, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
